// File: rtl/charger_pkg.sv
// Shared types and width helpers for the multi-port charge manager.
package charger_pkg;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ENTRY = 1'b1
    } entry_state_t;

    function automatic int amt_width(input int max_amount);
        return $clog2(max_amount + 1);
    endfunction

    function automatic int time_width(input int max_amount, input int sec_per_unit);
        return $clog2(max_amount * sec_per_unit + 1);
    endfunction

    function automatic int psel_width(input int num_ports);
        return (num_ports <= 1) ? 1 : $clog2(num_ports);
    endfunction

endpackage

// File: rtl/port_timer.sv
// Per-port countdown timer: loads a charge time, counts down on tick,
// pulses done on natural expiry. Abort beats load, load beats tick.
module port_timer #(
    parameter int TIME_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick,
    input  logic              load,
    input  logic [TIME_W-1:0] load_val,
    input  logic              abort,
    output logic [TIME_W-1:0] remaining,
    output logic              busy,
    output logic              done
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remaining <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else if (abort) begin
            remaining <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else if (load) begin
            remaining <= load_val;
            busy      <= (load_val != '0);
            done      <= 1'b0;
        end else if (tick && remaining != '0) begin
            remaining <= remaining - 1'b1;
            busy      <= (remaining != TIME_W'(1));
            done      <= (remaining == TIME_W'(1));
        end else begin
            done      <= 1'b0;
        end
    end

endmodule

// File: rtl/multi_port_charge_manager.sv
// Keypad amount entry with saturation, converted to charge time and
// committed to one of NUM_PORTS independent countdown timers.
module multi_port_charge_manager
    import charger_pkg::*;
#(
    parameter int  CLK_HZ       = 50_000_000,
    parameter int  TICK_HZ      = 1,
    parameter int  NUM_PORTS    = 2,
    parameter int  MAX_AMOUNT   = 20,
    parameter int  SEC_PER_UNIT = 2,
    parameter int  MAX_DIGITS   = 2,
    localparam int AMT_W        = amt_width(MAX_AMOUNT),
    localparam int TIME_W       = time_width(MAX_AMOUNT, SEC_PER_UNIT),
    localparam int PSEL_W       = psel_width(NUM_PORTS)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          key_valid,
    input  logic [3:0]                    key_value,
    input  logic [PSEL_W-1:0]             port_sel,
    input  logic                          start,
    input  logic                          cancel,
    output logic [AMT_W-1:0]              entry_amount,
    output logic                          entry_active,
    output logic [NUM_PORTS-1:0]          busy,
    output logic [NUM_PORTS*TIME_W-1:0]   remaining_time,
    output logic [NUM_PORTS-1:0]          done,
    output logic                          err
);

    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int CNT_W = $clog2(DIV);
    localparam int DIG_W = $clog2(MAX_DIGITS + 1);
    localparam int PAD_W = 1 << PSEL_W;
    localparam int ACC_W = AMT_W + 5;

    logic [CNT_W-1:0]     tick_cnt_reg;
    logic                 tick;
    entry_state_t         state_reg, state_next;
    logic [AMT_W-1:0]     amount_reg, amount_next;
    logic [DIG_W-1:0]     count_reg, count_next;
    logic                 err_reg, err_next;
    logic                 do_load, do_abort;
    logic [PAD_W-1:0]     busy_pad;
    logic                 sel_ok, sel_busy, start_ok, digit_ok;
    logic [ACC_W-1:0]     acc_wide;
    logic [AMT_W-1:0]     acc_sat;
    logic [TIME_W-1:0]    load_val;
    logic [NUM_PORTS-1:0] load_vec, abort_vec;

    assign tick = (tick_cnt_reg == CNT_W'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tick_cnt_reg <= '0;
        else if (tick)
            tick_cnt_reg <= '0;
        else
            tick_cnt_reg <= tick_cnt_reg + 1'b1;
    end

    // Pad busy to a power of two so any port_sel value indexes safely.
    always_comb begin
        busy_pad = '0;
        for (int i = 0; i < NUM_PORTS; i++)
            busy_pad[i] = busy[i];
    end

    assign sel_ok   = (int'(port_sel) < NUM_PORTS);
    assign sel_busy = busy_pad[port_sel];
    assign digit_ok = key_valid && (key_value <= 4'd9);
    assign start_ok = (state_reg == S_ENTRY) && (amount_reg != '0) && sel_ok && !sel_busy;

    // Wide accumulate so amount*10+digit cannot wrap before saturating.
    assign acc_wide = ((state_reg == S_ENTRY) ? ACC_W'(amount_reg) : ACC_W'(0)) * ACC_W'(10)
                      + ACC_W'(key_value);
    assign acc_sat  = (acc_wide > ACC_W'(MAX_AMOUNT)) ? AMT_W'(MAX_AMOUNT) : acc_wide[AMT_W-1:0];
    assign load_val = TIME_W'(int'(amount_reg) * SEC_PER_UNIT);

    always_comb begin
        state_next  = state_reg;
        amount_next = amount_reg;
        count_next  = count_reg;
        err_next    = 1'b0;
        do_load     = 1'b0;
        do_abort    = 1'b0;
        if (cancel) begin
            if (state_reg == S_ENTRY) begin
                state_next  = S_IDLE;
                amount_next = '0;
                count_next  = '0;
            end else if (sel_ok) begin
                do_abort = 1'b1;
            end
        end else if (start) begin
            if (start_ok) begin
                do_load     = 1'b1;
                state_next  = S_IDLE;
                amount_next = '0;
                count_next  = '0;
            end else begin
                err_next = 1'b1;
            end
        end else if (digit_ok) begin
            if (state_reg == S_IDLE) begin
                state_next  = S_ENTRY;
                amount_next = acc_sat;
                count_next  = DIG_W'(1);
            end else if (count_reg < DIG_W'(MAX_DIGITS)) begin
                amount_next = acc_sat;
                count_next  = count_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= S_IDLE;
            amount_reg <= '0;
            count_reg  <= '0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            amount_reg <= amount_next;
            count_reg  <= count_next;
            err_reg    <= err_next;
        end
    end

    assign entry_amount = amount_reg;
    assign entry_active = (state_reg == S_ENTRY);
    assign err          = err_reg;

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            assign load_vec[gi]  = do_load  && (port_sel == PSEL_W'(gi));
            assign abort_vec[gi] = do_abort && (port_sel == PSEL_W'(gi));

            port_timer #(
                .TIME_W (TIME_W)
            ) u_timer (
                .clk       (clk),
                .rst_n     (rst_n),
                .tick      (tick),
                .load      (load_vec[gi]),
                .load_val  (load_val),
                .abort     (abort_vec[gi]),
                .remaining (remaining_time[gi*TIME_W +: TIME_W]),
                .busy      (busy[gi]),
                .done      (done[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_multi_port_charge_manager.sv
// Directed bench with a behavioural model compared every cycle, plus
// hand-computed literal checks on the key scenarios.
module tb_multi_port_charge_manager;

    localparam int NP = 2;
    localparam int TW = 6;
    localparam int AW = 5;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           key_valid = 1'b0;
    logic [3:0]     key_value = 4'd0;
    logic           port_sel = 1'b0;
    logic           start = 1'b0;
    logic           cancel = 1'b0;
    logic [AW-1:0]  entry_amount;
    logic           entry_active;
    logic [NP-1:0]  busy;
    logic [NP*TW-1:0] remaining_time;
    logic [NP-1:0]  done;
    logic           err;

    always #5 clk = ~clk;

    multi_port_charge_manager #(
        .CLK_HZ       (10),
        .TICK_HZ      (1),
        .NUM_PORTS    (NP),
        .MAX_AMOUNT   (20),
        .SEC_PER_UNIT (2),
        .MAX_DIGITS   (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .key_valid      (key_valid),
        .key_value      (key_value),
        .port_sel       (port_sel),
        .start          (start),
        .cancel         (cancel),
        .entry_amount   (entry_amount),
        .entry_active   (entry_active),
        .busy           (busy),
        .remaining_time (remaining_time),
        .done           (done),
        .err            (err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: tick every 10th cycle, amount entry rules, per-port seconds left.
    int m_cnt, m_amt, m_dig;
    bit m_active, m_err, m_tick;
    int m_rem[NP];
    bit m_done[NP];

    always @(posedge clk or negedge rst_n) begin
        int ld, ldv, ab, ps;
        if (!rst_n) begin
            m_cnt = 0; m_amt = 0; m_dig = 0;
            m_active = 0; m_err = 0; m_tick = 0;
            for (int p = 0; p < NP; p++) begin
                m_rem[p] = 0;
                m_done[p] = 0;
            end
        end else begin
            m_tick = (m_cnt == 9);
            m_cnt = (m_cnt + 1) % 10;
            m_err = 0; ld = -1; ldv = 0; ab = -1;
            ps = int'(port_sel);
            if (cancel) begin
                if (m_active) begin
                    m_active = 0; m_amt = 0; m_dig = 0;
                end else begin
                    ab = ps;
                end
            end else if (start) begin
                if (m_active && m_amt > 0 && m_rem[ps] == 0) begin
                    ld = ps; ldv = m_amt * 2;
                    m_active = 0; m_amt = 0; m_dig = 0;
                end else begin
                    m_err = 1;
                end
            end else if (key_valid && key_value <= 9) begin
                if (!m_active) begin
                    m_active = 1;
                    m_amt = (int'(key_value) > 20) ? 20 : int'(key_value);
                    m_dig = 1;
                end else if (m_dig < 2) begin
                    m_amt = m_amt * 10 + int'(key_value);
                    if (m_amt > 20) m_amt = 20;
                    m_dig++;
                end
            end
            for (int p = 0; p < NP; p++) begin
                m_done[p] = 0;
                if (p == ab) m_rem[p] = 0;
                else if (p == ld) m_rem[p] = ldv;
                else if (m_tick && m_rem[p] > 0) begin
                    m_rem[p]--;
                    m_done[p] = (m_rem[p] == 0);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("entry_amount", int'(entry_amount), m_amt);
            check("entry_active", int'(entry_active), int'(m_active));
            check("err", int'(err), int'(m_err));
            for (int p = 0; p < NP; p++) begin
                check($sformatf("remaining%0d", p), int'(remaining_time[p*TW +: TW]), m_rem[p]);
                check($sformatf("busy%0d", p), int'(busy[p]), int'(m_rem[p] != 0));
                check($sformatf("done%0d", p), int'(done[p]), int'(m_done[p]));
            end
        end
    end

    function automatic int rem(input int p);
        return int'(remaining_time[p*TW +: TW]);
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press_key(input int d);
        key_valid = 1'b1;
        key_value = 4'(d);
        step(1);
        key_valid = 1'b0;
    endtask

    task automatic do_start(input int p);
        port_sel = 1'(p);
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic do_cancel(input int p);
        port_sel = 1'(p);
        cancel = 1'b1;
        step(1);
        cancel = 1'b0;
    endtask

    task automatic wait_cnt(input int c, input string name);
        int n;
        n = 0;
        while (m_cnt != c && n < 20) begin
            step(1);
            n++;
        end
        if (m_cnt != c) check(name, m_cnt, c);
    endtask

    initial begin
        int tk, d0, d1;
        #1 rst_n = 1'b0;
        #1;
        check("rst_entry_amount", int'(entry_amount), 0);
        check("rst_outputs", int'({entry_active, busy, remaining_time, done, err}), 0);
        step(2);
        rst_n = 1'b1;

        // 1,5 -> 30 ticks on port 0
        press_key(1);
        press_key(5);
        check("t1_amount", int'(entry_amount), 15);
        do_start(0);
        check("t1_rem0", rem(0), 30);
        check("t1_busy0", int'(busy[0]), 1);
        tk = 0; d0 = -1;
        for (int i = 0; i < 400 && d0 < 0; i++) begin
            step(1);
            if (m_tick) tk++;
            if (done[0]) d0 = tk;
        end
        check("t1_done_tick", d0, 30);
        check("t1_busy0_end", int'(busy[0]), 0);
        step(1);
        check("t1_done_single", int'(done[0]), 0);

        // Saturation and ignored third digit
        press_key(9);
        check("t2_amt9", int'(entry_amount), 9);
        press_key(9);
        check("t2_amt_sat", int'(entry_amount), 20);
        press_key(5);
        check("t2_third_ignored", int'(entry_amount), 20);
        do_start(1);
        check("t2_rem1", rem(1), 40);

        // Rejected starts and cancels
        press_key(3);
        do_start(1);
        check("t3_err_busy", int'(err), 1);
        check("t3_entry_kept", int'(entry_amount), 3);
        step(1);
        check("t3_err_pulse", int'(err), 0);
        do_cancel(1);
        check("t3_entry_cancel", int'(entry_active), 0);
        check("t3_port1_running", int'(busy[1]), 1);
        do_start(0);
        check("t3_err_idle", int'(err), 1);
        press_key(0);
        do_start(0);
        check("t3_err_zero", int'(err), 1);
        check("t3_zero_active", int'(entry_active), 1);
        do_cancel(0);
        do_cancel(1);
        check("t3_abort_rem1", rem(1), 0);
        check("t3_abort_done", int'(done[1]), 0);
        step(1);
        check("t3_abort_no_done", int'(done[1]), 0);

        // Start and cancel together: cancel wins
        press_key(2);
        port_sel = 1'b0; start = 1'b1; cancel = 1'b1;
        step(1);
        start = 1'b0; cancel = 1'b0;
        check("t4_no_load", rem(0), 0);
        check("t4_idle", int'(entry_active), 0);

        // Load on the tick edge: no decrement
        press_key(4);
        wait_cnt(9, "t4_align");
        do_start(0);
        check("t4_load_tick", rem(0), 8);
        do_cancel(0);

        // Both ports in lockstep: 4 and 6 ticks
        wait_cnt(0, "t5_align");
        press_key(2);
        do_start(0);
        press_key(3);
        do_start(1);
        check("t5_rem0", rem(0), 4);
        check("t5_rem1", rem(1), 6);
        tk = 0; d0 = -1; d1 = -1;
        for (int i = 0; i < 200 && d1 < 0; i++) begin
            step(1);
            if (m_tick) tk++;
            if (done[0]) d0 = tk;
            if (done[1]) d1 = tk;
        end
        check("t5_done0_tick", d0, 4);
        check("t5_done1_tick", d1, 6);

        // Async reset mid-countdown, then tick phase after release
        press_key(5);
        do_start(0);
        step(3);
        rst_n = 1'b0;
        #1;
        check("t6_rst_rem", int'(remaining_time), 0);
        check("t6_rst_outputs", int'({entry_amount, entry_active, busy, done, err}), 0);
        step(1);
        rst_n = 1'b1;
        press_key(1);
        do_start(0);
        step(7);
        check("t6_before_tick", rem(0), 2);
        step(1);
        check("t6_first_tick", rem(0), 1);
        step(12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_port_charge_manager.md
# multi_port_charge_manager

Parametrised successor to the single-port amount/timer manager in the coin-operated charger. It accepts a keypad-entered amount, saturates it to a configurable maximum, and converts it into charge time at a configurable rate. That time is committed to one of NUM_PORTS independent countdown timers, which can be aborted individually. It sits between the keypad decoder and the per-port display/relay drivers, and generates its own tick from the system clock.

## Interface
- CLK_HZ, 50_000_000: system clock frequency.
- TICK_HZ, 1: countdown rate; CLK_HZ/TICK_HZ must be an integer of at least 2.
- NUM_PORTS, 2: number of independent charging ports, 1..8.
- MAX_AMOUNT, 20: saturation value of the entered amount.
- SEC_PER_UNIT, 2: ticks of charge per money unit.
- MAX_DIGITS, 2: digits accepted per entry.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- key_valid  in  1  one-cycle strobe, key_value valid.
- key_value  in  4  digit 0-9; values 10-15 are ignored.
- port_sel  in  PSEL_W=max(1,$clog2(NUM_PORTS))  target port for start/cancel.
- start  in  1  one-cycle strobe, commit entry to port_sel.
- cancel  in  1  one-cycle strobe, clear entry or abort port.
- entry_amount  out  AMT_W=$clog2(MAX_AMOUNT+1)  amount being entered.
- entry_active  out  1  entry FSM in ENTRY.
- busy  out  NUM_PORTS  port timer nonzero.
- remaining_time  out  NUM_PORTS*TIME_W, TIME_W=$clog2(MAX_AMOUNT*SEC_PER_UNIT+1)  packed; port i at [i*TIME_W +: TIME_W].
- done  out  NUM_PORTS  one-cycle pulse per port on natural expiry.
- err  out  1  one-cycle pulse on rejected start.

## Operation
- Tick: a free-running counter counts 0..CLK_HZ/TICK_HZ-1 and pulses tick for one cycle at the terminal count. Nothing resets it except rst_n.
- Entry FSM has two states.
- IDLE: entry_amount=0, digit count=0. A valid digit (key_valid with key_value<=9) moves to ENTRY with entry_amount=min(digit,MAX_AMOUNT) and count=1.
- ENTRY, valid digit with count<MAX_DIGITS: entry_amount=min(entry_amount*10+digit, MAX_AMOUNT), computed wide enough not to overflow; count increments.
- ENTRY, valid digit with count==MAX_DIGITS: digit ignored.
- ENTRY, start with entry_amount==0 or busy[port_sel]: err pulses and the FSM stays in ENTRY, amount unchanged.
- ENTRY, start otherwise: load port_sel timer with entry_amount*SEC_PER_UNIT, then go to IDLE.
- ENTRY, cancel: go to IDLE with no err.
- IDLE, start: err pulses; no other effect.
- IDLE, cancel: port_sel timer goes to 0 and busy drops; no done pulse.
- Same-cycle priority: cancel over start, start over key_valid. A key arriving with start or cancel is dropped.
- port_sel >= NUM_PORTS: start gives err, cancel does nothing.
- Timer on tick: if nonzero, decrement. A 1->0 transition pulses done in the same cycle that remaining_time shows 0.
- Timer, load and tick in the same cycle: the load wins and no decrement happens.
- Timer, abort and tick in the same cycle: the abort wins and no done pulse occurs.
- Timers are independent; all ports may run at once.

## Timing
- Reset values (immediate on rst_n low): FSM=IDLE, tick counter=0, all timers=0, and every output 0 (entry_amount, entry_active, busy, remaining_time, done, err).
- All outputs are registered.
- Strobe sampled at edge n: entry_amount, entry_active, the loaded timer, busy, and err are all visible after edge n. The entry FSM returns to IDLE on the same edge.
- Ticks are tick-rate accurate with up to one tick of phase error at load.
- Charge duration is remaining_time_loaded ticks.

## Structure
- Package charger_pkg holds the entry FSM state enum (S_IDLE, S_ENTRY) and width helper functions for AMT_W, TIME_W, and PSEL_W.
- Sub-module port_timer, instantiated NUM_PORTS times via generate. Ports: clk, rst_n, tick, load, load_val, abort, remaining, busy, done.
- The tick generator, entry FSM, and saturating accumulator stay in the top module.

## Test plan
All scenarios use CLK_HZ=10, TICK_HZ=1 (tick every 10 cycles) unless stated.
- Digits 1, 5 then start with port_sel=0: remaining_time[0]=30 and busy[0]=1 the next cycle; 30 ticks later done[0] pulses once and busy[0]=0.
- Digits 9, 9: entry_amount=9 then 20 (saturated). A third digit is ignored. Start with port 1 loads 40.
- Start at amount 0 or on a busy port gives err=1 for one cycle, entry retained. IDLE cancel on a running port gives remaining_time 0, no done.
- Load and tick on the same edge for port 0: value equals the load with no decrement. Start and cancel together: cancel wins, no load.
- Both ports loaded (4 and 6): they decrement in lockstep, done[0] at tick 4 and done[1] at tick 6.
- rst_n low mid-countdown: all outputs 0 asynchronously. After release the first tick comes 10 cycles later.
